// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port
// 32-bit synchronous RAM. One transaction in flight at a time; each takes
// three cycles (IDLE sample, ACCESS, DONE/ack).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   mN_req/we/addr/wdata  requester N inputs (byte address, held until ack)
//   mN_rdata/ack/err      requester N completion (valid while ack = 1)
//   ram_addr/we/din       RAM command; ram_dout returns the cycle after ram_addr
//   busy                  FSM not in IDLE
//   grant_cnt0/1          saturating completed-transaction counters
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the winner's command
// ACCESS | drive the latched command to the RAM
// DONE   | ack the granted port with read data / range error
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nx;
    logic        grant, grant_nx;
    logic        last_grant;
    logic        we_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic        in_range;
    logic        take;

    // Byte-lane bits are not used: the RAM is word addressed.
    logic        unused_lane_bits;
    assign unused_lane_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    assign in_range = (addr_q[31:ADDR_W+2] == '0);
    assign take     = (state == IDLE) && (m0_req || m1_req);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    grant_nx = ~last_grant;
                    state_nx = ACCESS;
                end else if (m0_req) begin
                    grant_nx = 1'b0;
                    state_nx = ACCESS;
                end else if (m1_req) begin
                    grant_nx = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b1;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            if (take) begin
                we_q    <= grant_nx ? m1_we          : m0_we;
                addr_q  <= grant_nx ? m1_addr[31:2]  : m0_addr[31:2];
                wdata_q <= grant_nx ? m1_wdata       : m0_wdata;
            end
            if (state == DONE) begin
                last_grant <= grant;
                if (!grant && grant_cnt0 != {CNT_W{1'b1}})
                    grant_cnt0 <= grant_cnt0 + 1'b1;
                if (grant && grant_cnt1 != {CNT_W{1'b1}})
                    grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end

    // addr_q/wdata_q only change when a new grant is taken, so the RAM
    // command lines hold their last values outside ACCESS.
    assign ram_addr = addr_q[ADDR_W+1:2];
    assign ram_din  = wdata_q;
    // Gated by rst so a reset landing on ACCESS cannot commit the write.
    assign ram_we   = (state == ACCESS) && we_q && in_range && rst;
    assign busy     = (state != IDLE);

    assign m0_ack   = (state == DONE) && !grant;
    assign m1_ack   = (state == DONE) &&  grant;
    assign m0_err   = m0_ack && !in_range;
    assign m1_err   = m1_ack && !in_range;
    assign m0_rdata = (m0_ack && !we_q && in_range) ? ram_dout : 32'h0;
    assign m1_rdata = (m1_ack && !we_q && in_range) ? ram_dout : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;
    logic [15:0] grant_cnt0, grant_cnt1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Synchronous read-first RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the FSM in IDLE. Returns what was seen in the
    // ACCESS cycle and in the DONE (ack) cycle; ends at a negedge in IDLE.
    logic        t_acc_we, t_done_we, t_early_ack, t_ack, t_err, t_other_ack;
    logic [9:0]  t_acc_addr;
    logic [31:0] t_acc_din, t_rdata;

    task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        @(negedge clk);
        t_acc_we    = ram_we;
        t_acc_addr  = ram_addr;
        t_acc_din   = ram_din;
        t_early_ack = m0_ack | m1_ack;
        @(negedge clk);
        t_done_we   = ram_we;
        t_ack       = port ? m1_ack   : m0_ack;
        t_err       = port ? m1_err   : m0_err;
        t_rdata     = port ? m1_rdata : m0_rdata;
        t_other_ack = port ? m0_ack   : m1_ack;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        do_reset();

        check("rst_busy",   {31'b0, busy},   32'd0);
        check("rst_ack0",   {31'b0, m0_ack}, 32'd0);
        check("rst_ack1",   {31'b0, m1_ack}, 32'd0);
        check("rst_err0",   {31'b0, m0_err}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_rdata0", m0_rdata,        32'd0);
        check("rst_cnt0",   {16'b0, grant_cnt0}, 32'd0);
        check("rst_cnt1",   {16'b0, grant_cnt1}, 32'd0);

        // m0 write 0x20 <- 0xFFFFFFF0
        txn(1'b0, 1'b1, 32'h20, 32'hFFFF_FFF0);
        check("wr_acc_we",   {31'b0, t_acc_we},    32'd1);
        check("wr_acc_addr", {22'b0, t_acc_addr},  32'd8);
        check("wr_acc_din",  t_acc_din,            32'hFFFF_FFF0);
        check("wr_no_early", {31'b0, t_early_ack}, 32'd0);
        check("wr_we_1cyc",  {31'b0, t_done_we},   32'd0);
        check("wr_ack",      {31'b0, t_ack},       32'd1);
        check("wr_err",      {31'b0, t_err},       32'd0);
        check("wr_rdata",    t_rdata,              32'd0);
        check("wr_cnt0",     {16'b0, grant_cnt0},  32'd1);
        check("wr_idle",     {31'b0, busy},        32'd0);

        // m0 read 0x20
        txn(1'b0, 1'b0, 32'h20, 32'h0);
        check("rd_ack",   {31'b0, t_ack}, 32'd1);
        check("rd_err",   {31'b0, t_err}, 32'd0);
        check("rd_rdata", t_rdata,        32'hFFFF_FFF0);

        // m1 out-of-range write
        txn(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        check("oob_we",    {31'b0, t_acc_we},    32'd0);
        check("oob_ack",   {31'b0, t_ack},       32'd1);
        check("oob_err",   {31'b0, t_err},       32'd1);
        check("oob_rdata", t_rdata,              32'd0);
        check("oob_other", {31'b0, t_other_ack}, 32'd0);
        check("oob_cnt1",  {16'b0, grant_cnt1},  32'd1);

        // Known value at 0x40 for the abort test.
        txn(1'b0, 1'b1, 32'h40, 32'hA5A5_A5A5);
        check("pre_ack", {31'b0, t_ack}, 32'd1);

        // Round robin: both held from a fresh reset, port 0 wins first tie.
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        seen = 0;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                check("rr_one_ack", {31'b0, m0_ack ^ m1_ack}, 32'd1);
                check("rr_order",   {31'b0, m1_ack}, {31'b0, seen[0]});
                check("rr_rdata",   m1_ack ? m1_rdata : m0_rdata, 32'hFFFF_FFF0);
                seen++;
                if (seen == 4) begin
                    m0_req = 0;
                    m1_req = 0;
                end
            end
        end
        check("rr_acks", seen, 32'd4);
        repeat (2) @(negedge clk);
        check("rr_cnt0", {16'b0, grant_cnt0}, 32'd2);
        check("rr_cnt1", {16'b0, grant_cnt1}, 32'd2);

        // Reset during ACCESS of an m0 write.
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h1234_5678;
        @(negedge clk);
        check("ab_in_access", {31'b0, ram_we}, 32'd1);
        rst = 0;
        m0_req = 0;
        @(negedge clk);
        check("ab_busy",   {31'b0, busy},   32'd0);
        check("ab_ack0",   {31'b0, m0_ack}, 32'd0);
        check("ab_ram_we", {31'b0, ram_we}, 32'd0);
        check("ab_rdata0", m0_rdata,        32'd0);
        check("ab_cnt0",   {16'b0, grant_cnt0}, 32'd0);
        check("ab_mem",    mem[16],         32'hA5A5_A5A5);
        rst = 1;
        repeat (2) begin
            @(negedge clk);
            check("ab_no_ack", {31'b0, m0_ack | m1_ack}, 32'd0);
        end
        txn(1'b0, 1'b0, 32'h40, 32'h0);
        check("ab_readback", t_rdata, 32'hA5A5_A5A5);

        // Counter saturation.
        force dut.grant_cnt1 = 16'hFFFF;
        #1;
        release dut.grant_cnt1;
        check("sat_pre", {16'b0, grant_cnt1}, 32'h0000_FFFF);
        txn(1'b1, 1'b0, 32'h20, 32'h0);
        check("sat_ack",  {31'b0, t_ack},        32'd1);
        check("sat_cnt1", {16'b0, grant_cnt1},   32'h0000_FFFF);
        check("sat_cnt0", {16'b0, grant_cnt0},   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
